// File: rtl/tone_pkg.sv
// Shared constants, state type and clamp helper for the period_tone_gen slice.
package tone_pkg;

    localparam int unsigned PERIOD_W = 24;
    localparam logic [PERIOD_W-1:0] DEFAULT_PERIOD = 24'd1000;
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = 24'd2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tone_state_t;

    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

endpackage

// File: rtl/period_tone_gen_if.sv
// Period handshake and tone outputs; the producer side is master, the generator is slave.
// Optional mute input is present only when PERIOD_TONE_GEN_MUTE_EN is defined.
interface period_tone_gen_if
    import tone_pkg::*;
#(
    parameter int unsigned Width = PERIOD_W
);
    logic             enable;
    logic [Width-1:0] period_in;
    logic             period_valid;
    logic             period_ready;
    logic             wave_out;
    logic             tick;
    logic [Width-1:0] period_active;
    logic             busy;
`ifdef PERIOD_TONE_GEN_MUTE_EN
    logic             mute;

    modport master (
        output enable, period_in, period_valid, mute,
        input  period_ready, wave_out, tick, period_active, busy
    );
    modport slave (
        input  enable, period_in, period_valid, mute,
        output period_ready, wave_out, tick, period_active, busy
    );
`else
    modport master (
        output enable, period_in, period_valid,
        input  period_ready, wave_out, tick, period_active, busy
    );
    modport slave (
        input  enable, period_in, period_valid,
        output period_ready, wave_out, tick, period_active, busy
    );
`endif

endinterface

// File: rtl/half_period_counter.sv
// Half-wave cycle counter: flags the last cycle of a half-wave and restarts itself.
module half_period_counter #(
    parameter int unsigned Width = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [Width-1:0] limit_i,
    output logic             wrap_o
);

    logic [Width-1:0] count_q, count_d;

    // limit_i is never below 2, so limit_i - 1 cannot underflow.
    assign wrap_o = (count_q == (limit_i - Width'(1)));

    always_comb begin
        count_d = count_q + Width'(1);
        if (clear_i || wrap_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/period_tone_gen.sv
// Square-wave tone generator; new periods take effect only at half-wave boundaries.
// Optional output mute is enabled by defining PERIOD_TONE_GEN_MUTE_EN.
module period_tone_gen
    import tone_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    period_tone_gen_if.slave   bus
);

    tone_state_t         state_q, state_d;
    logic [PERIOD_W-1:0] period_active_q, period_active_d;
    logic [PERIOD_W-1:0] pend_val_q, pend_val_d;
    logic                pend_full_q, pend_full_d;
    logic                phase_q, phase_d;
    logic                tick_q, tick_d;
    logic                running;
    logic                wrap;

    assign running = (state_q == RUN) && bus.enable;

    half_period_counter #(
        .Width (PERIOD_W)
    ) u_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (!running),
        .limit_i (period_active_q),
        .wrap_o  (wrap)
    );

    always_comb begin
        state_d         = state_q;
        period_active_d = period_active_q;
        pend_val_d      = pend_val_q;
        pend_full_d     = pend_full_q;
        phase_d         = phase_q;
        tick_d          = 1'b0;

        unique case (state_q)
            IDLE: begin
                phase_d = 1'b0;
                if (pend_full_q) begin
                    period_active_d = pend_val_q;
                    pend_full_d     = 1'b0;
                end
                if (bus.enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    phase_d = 1'b0;
                end else if (wrap) begin
                    phase_d = ~phase_q;
                    tick_d  = 1'b1;
                    if (pend_full_q) begin
                        period_active_d = pend_val_q;
                        pend_full_d     = 1'b0;
                    end
                end
            end
        endcase

        // Accept needs an empty buffer, so it never collides with an apply above;
        // a value accepted on a boundary waits for the following one.
        if (bus.period_valid && !pend_full_q) begin
            pend_val_d  = clamp_period(bus.period_in);
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            period_active_q <= DEFAULT_PERIOD;
            pend_val_q      <= '0;
            pend_full_q     <= 1'b0;
            phase_q         <= 1'b0;
            tick_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            period_active_q <= period_active_d;
            pend_val_q      <= pend_val_d;
            pend_full_q     <= pend_full_d;
            phase_q         <= phase_d;
            tick_q          <= tick_d;
        end
    end

    assign bus.period_ready  = !pend_full_q;
    assign bus.tick          = tick_q;
    assign bus.period_active = period_active_q;
    assign bus.busy          = (state_q == RUN);
`ifdef PERIOD_TONE_GEN_MUTE_EN
    assign bus.wave_out      = phase_q && !bus.mute;
`else
    assign bus.wave_out      = phase_q;
`endif

endmodule

// File: tb/tb_period_tone_gen.sv
// Directed self-checking bench for period_tone_gen; all I/O sampled and driven on negedge.
module tb_period_tone_gen;
    import tone_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   n;

    period_tone_gen_if #(.Width(PERIOD_W)) bus ();

    period_tone_gen dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Cycles from now until the next tick pulse, bounded.
    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.tick && cycles < 5000);
    endtask

    task automatic set_period_idle(input logic [PERIOD_W-1:0] p, input int exp, input string tag);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.period_in    = p;
        bus.period_valid = 1'b1;
        @(negedge clk);
        bus.period_valid = 1'b0;
        check_eq({tag, "_ready_low"}, 32'(bus.period_ready), 32'd0);
        @(negedge clk);
        check_eq({tag, "_active"}, 32'(bus.period_active), 32'(exp));
        check_eq({tag, "_ready_back"}, 32'(bus.period_ready), 32'd1);
    endtask

    task automatic start_run();
        bus.enable = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bus.enable       = 1'b0;
        bus.period_in    = '0;
        bus.period_valid = 1'b0;
`ifdef PERIOD_TONE_GEN_MUTE_EN
        bus.mute         = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_wave", 32'(bus.wave_out), 32'd0);
        check_eq("rst_tick", 32'(bus.tick), 32'd0);
        check_eq("rst_active", 32'(bus.period_active), 32'd1000);
        check_eq("rst_ready", 32'(bus.period_ready), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);

        // Default period after reset.
        rst_n = 1'b1;
        start_run();
        check_eq("def_busy", 32'(bus.busy), 32'd1);
        check_eq("def_wave0", 32'(bus.wave_out), 32'd0);
        wait_tick(n);
        check_eq("def_first_half", 32'(n), 32'd1000);
        check_eq("def_wave_hi", 32'(bus.wave_out), 32'd1);
        wait_tick(n);
        check_eq("def_second_half", 32'(n), 32'd1000);
        check_eq("def_wave_lo", 32'(bus.wave_out), 32'd0);

        // Period 4 written in IDLE.
        set_period_idle(24'd4, 4, "p4");
        start_run();
        wait_tick(n);
        check_eq("p4_low_half", 32'(n), 32'd4);
        wait_tick(n);
        check_eq("p4_high_half", 32'(n), 32'd4);

        // 8 -> 16 written mid half-wave.
        set_period_idle(24'd8, 8, "p8");
        start_run();
        repeat (3) @(negedge clk);
        bus.period_in    = 24'd16;
        bus.period_valid = 1'b1;
        @(negedge clk);
        bus.period_valid = 1'b0;
        check_eq("mid_ready_low", 32'(bus.period_ready), 32'd0);
        check_eq("mid_active_old", 32'(bus.period_active), 32'd8);
        wait_tick(n);
        check_eq("mid_finish_8", 32'(n), 32'd4);
        check_eq("mid_active_new", 32'(bus.period_active), 32'd16);
        check_eq("mid_ready_back", 32'(bus.period_ready), 32'd1);
        wait_tick(n);
        check_eq("mid_half_16", 32'(n), 32'd16);

        // Clamping of 0 and 1.
        set_period_idle(24'd0, 2, "clamp0");
        set_period_idle(24'd5, 5, "p5");
        set_period_idle(24'd1, 2, "clamp1");
        start_run();
        wait_tick(n);
        check_eq("clamp_half_a", 32'(n), 32'd2);
        wait_tick(n);
        check_eq("clamp_half_b", 32'(n), 32'd2);

        // Accept on the boundary cycle (10 -> 6), second write refused.
        set_period_idle(24'd10, 10, "p10");
        start_run();
        repeat (9) @(negedge clk);
        bus.period_in    = 24'd6;
        bus.period_valid = 1'b1;
        @(negedge clk);
        check_eq("bnd_tick", 32'(bus.tick), 32'd1);
        check_eq("bnd_active_kept", 32'(bus.period_active), 32'd10);
        check_eq("bnd_ready_low", 32'(bus.period_ready), 32'd0);
        bus.period_in = 24'd3;
        @(negedge clk);
        bus.period_valid = 1'b0;
        check_eq("bnd_ready_still_low", 32'(bus.period_ready), 32'd0);
        wait_tick(n);
        check_eq("bnd_half_10", 32'(n), 32'd9);
        check_eq("bnd_active_6", 32'(bus.period_active), 32'd6);
        check_eq("bnd_ready_back", 32'(bus.period_ready), 32'd1);
        wait_tick(n);
        check_eq("bnd_half_6", 32'(n), 32'd6);
        check_eq("bnd_no_second", 32'(bus.period_active), 32'd6);

        // Enable dropped mid half-wave while wave_out is high.
        repeat (2) @(negedge clk);
        check_eq("dis_wave_hi", 32'(bus.wave_out), 32'd1);
        bus.enable = 1'b0;
        @(negedge clk);
        check_eq("dis_busy", 32'(bus.busy), 32'd0);
        check_eq("dis_wave", 32'(bus.wave_out), 32'd0);
        check_eq("dis_tick", 32'(bus.tick), 32'd0);
        start_run();
        wait_tick(n);
        check_eq("dis_restart_half", 32'(n), 32'd6);

        // Async reset mid-RUN with a pending value.
        bus.period_in    = 24'd20;
        bus.period_valid = 1'b1;
        @(negedge clk);
        bus.period_valid = 1'b0;
        check_eq("ar_pending", 32'(bus.period_ready), 32'd0);
        check_eq("ar_wave_hi", 32'(bus.wave_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_wave", 32'(bus.wave_out), 32'd0);
        check_eq("ar_busy", 32'(bus.busy), 32'd0);
        check_eq("ar_active", 32'(bus.period_active), 32'd1000);
        check_eq("ar_ready", 32'(bus.period_ready), 32'd1);
        @(negedge clk);
        rst_n      = 1'b1;
        bus.enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("ar_pend_lost", 32'(bus.period_active), 32'd1000);
        check_eq("ar_ready_after", 32'(bus.period_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/period_tone_gen.md
Name: period_tone_gen

Overview:
Consumes the 24-bit period word produced by the period-adjust logic and generates the corresponding square wave for the audio/tone path. A valid/ready handshake updates the period. New periods are applied only at half-wave boundaries, so the output never glitches. Sits between the period-adjust stage and the audio output mux.

Parameters:
PERIOD_W, 24, width of period words and internal counter
DEFAULT_PERIOD, 24'd1000, half-wave length in clk cycles loaded at reset
MIN_PERIOD, 24'd2, smallest accepted half-wave length; smaller requests are clamped up to it

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  run tone generation when high
period_in  input  PERIOD_W  requested half-wave length, in clk cycles
period_valid  input  1  period_in is valid
period_ready  output  1  block can accept a period this cycle
wave_out  output  1  square-wave output
tick  output  1  one-cycle pulse on every wave_out toggle
period_active  output  PERIOD_W  half-wave length currently in use
busy  output  1  high while in RUN

Behaviour:
- Reset (reset==0, async): state=IDLE, count=0, wave_out=0, tick=0, period_active=DEFAULT_PERIOD, pending empty, period_ready=1, busy=0.
- Pending buffer holds one entry: pend_val and pend_full. period_ready = !pend_full. Accept occurs when period_valid && period_ready. On accept, pend_val = max(period_in, MIN_PERIOD) and pend_full=1.
- States:
  - IDLE: count=0, wave_out=0, tick=0. If pend_full, move pend_val to period_active and clear pend_full, one cycle after accept. enable=1 -> RUN next cycle.
  - RUN: busy=1. Each cycle count++. When count==period_active-1, this is a boundary:
    - count<=0, wave_out toggles, tick=1 that cycle (registered, coincident with the toggle).
    - If pend_full was set at the start of the cycle, period_active<=pend_val and pend_full<=0.
  - RUN with enable=0 -> IDLE next cycle: count=0, wave_out=0. No tick is generated by the forced low.
- Simultaneous accept and boundary: the newly accepted value is not applied at that boundary. It waits for the next boundary; period_ready drops the following cycle.
- A pending value applies at the next boundary. period_ready returns to 1 the cycle after application.
- Full waveform period = 2*period_active cycles. Duty is exactly 50%.
- period_in < MIN_PERIOD (including 0) is clamped; it is never rejected.
- Counter width is PERIOD_W. count never exceeds period_active-1, so there is no wrap-around hazard.
- An async reset mid-wave returns immediately to the reset values. Any pending value is discarded.

Optional Feature:
PERIOD_TONE_GEN_MUTE_EN. When defined:
- Adds input mute (1 bit).
- wave_out is forced to 0 while mute=1, but the internal phase and counter keep running.
- tick is unaffected, so unmuting resumes in phase.
When undefined: no mute port; wave_out comes directly from the phase register.

Decomposition:
- Package tone_pkg: PERIOD_W, DEFAULT_PERIOD, MIN_PERIOD, and the state enum typedef tone_state_t {IDLE, RUN}.
- One sub-module, half_period_counter: inputs clk, reset, clear, limit; output wrap. Contains count and the count==limit-1 compare.
- Handshake, pending buffer and FSM stay in the top.

Test Plan:
- Reset release, enable=1, no period writes -> wave_out first toggles 1000 cycles after entering RUN; tick pulses every 1000 cycles; period_active=1000.
- Write period 4 during IDLE -> period_active=4 one cycle after accept; in RUN, wave_out high 4 cycles / low 4 cycles.
- RUN at period 8, write 16 mid-half-wave -> current half-wave completes at 8 cycles; next half-wave is 16; period_ready low from the cycle after accept until the cycle after application.
- Write 0 and 1 -> period_active=2 (clamped); wave_out toggles every 2 cycles.
- period_valid asserted on the boundary cycle with value 6 (old 10) -> next half-wave still 10, the one after 6; a second write while pend_full sees period_ready=0 and is not accepted.
- Drop enable mid-wave, then assert async reset mid-RUN -> IDLE next cycle, wave_out=0, count=0 with no tick; on reset, immediate return to reset values and the pending value is lost.
